hart_regelaar: RTL and testbench

//  Sequencing controller for the heart-rate datapath (clock divider + rhythm meter).
//  - Detects beats on the raw heartbeat input and checks beat intervals, counted in divider ticks.
//  - Acquires lock after a run of plausible beats, then publishes the meter result with a valid flag.
//  - On signal loss it resets the meter and retries; after repeated failures it slows the divider.

---
 rtl/hart_pkg.sv | 30 +++
 rtl/hart_beat_detect.sv | 31 +++
 rtl/hart_regelaar.sv | 187 ++++++++++++++++++
 tb/tb_hart_regelaar.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hart_pkg.sv
// Shared constants, state encoding and helpers for the heart-rate sequencing controller.
package hart_pkg;

  localparam int          DEF_TIMEOUT_TICKS = 200;
  localparam int          DEF_MIN_TICKS     = 20;
  localparam int          DEF_LOCK_BEATS    = 4;
  localparam int          DEF_MAX_RETRY     = 3;
  localparam logic [7:0]  DEF_SNELHEID_INIT = 8'd100;
  localparam logic [7:0]  DEF_SNELHEID_STAP = 8'd10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ZOEK     = 3'd1,
    METEN    = 3'd2,
    VOLG     = 3'd3,
    VERLOREN = 3'd4
  } state_t;

  // Divider setting may only grow up to its 8-bit ceiling.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[8]) begin
      return 8'hFF;
    end else begin
      return sum[7:0];
    end
  endfunction

endpackage

// File: rtl/hart_beat_detect.sv
// Synchronises the raw heartbeat input and turns each rising edge into a registered 1-clk pulse.
module hart_beat_detect (
  input  logic clk,
  input  logic reset,
  input  logic puls,
  output logic beat
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;
  logic beat_r;

  // Two-flop synchroniser followed by a registered rising-edge detector.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      beat_r  <= 1'b0;
    end else begin
      sync1_r <= puls;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      beat_r  <= sync2_r & ~prev_r;
    end
  end

  assign beat = beat_r;

endmodule

// File: rtl/hart_regelaar.sv
// Heart-rate sequencing controller: beat interval checking, lock acquisition,
// loss handling with meter reset and divider slow-down.
module hart_regelaar
  import hart_pkg::*;
#(
  parameter int         TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int         MIN_TICKS     = DEF_MIN_TICKS,
  parameter int         LOCK_BEATS    = DEF_LOCK_BEATS,
  parameter int         MAX_RETRY     = DEF_MAX_RETRY,
  parameter logic [7:0] SNELHEID_INIT = DEF_SNELHEID_INIT,
  parameter logic [7:0] SNELHEID_STAP = DEF_SNELHEID_STAP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       tick,
  input  logic       hartslagIngang,
  input  logic [7:0] meting,
  output logic [7:0] ClockSnelheid,
  output logic       meetReset,
  output logic [7:0] hartslag,
  output logic       geldig,
  output logic       verloren,
  output logic [2:0] toestand
);

  localparam int CNT_W   = $clog2(TIMEOUT_TICKS + 1);
  localparam int BEAT_W  = $clog2(LOCK_BEATS + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0]   CNT_MIN   = CNT_W'(MIN_TICKS);
  localparam logic [BEAT_W-1:0]  BEAT_LOCK = BEAT_W'(LOCK_BEATS);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_t               state_r,     state_s;
  logic [CNT_W-1:0]     cnt_r,       cnt_s;
  logic [BEAT_W-1:0]    beatcnt_r,   beatcnt_s;
  logic [RETRY_W-1:0]   retry_r,     retry_s;
  logic [RETRY_W-1:0]   retry_inc_s;
  logic [7:0]           snelheid_r,  snelheid_s;
  logic [7:0]           hartslag_r,  hartslag_s;
  logic                 meetreset_r, meetreset_s;
  logic                 geldig_r,    geldig_s;
  logic                 verloren_r,  verloren_s;

  logic beat_s;
  logic accept_s;
  logic timeout_s;

  hart_beat_detect u_beat (
    .clk   (clk),
    .reset (reset),
    .puls  (hartslagIngang),
    .beat  (beat_s)
  );

  assign accept_s    = beat_s && (cnt_r >= CNT_MIN);
  assign timeout_s   = (cnt_r == CNT_MAX);
  assign retry_inc_s = retry_r + RETRY_W'(1);

  // Next state and next register values; an accepted beat always wins over a timeout.
  always_comb begin
    state_s    = state_r;
    beatcnt_s  = beatcnt_r;
    retry_s    = retry_r;
    snelheid_s = snelheid_r;
    hartslag_s = hartslag_r;
    geldig_s   = geldig_r;
    verloren_s = verloren_r;

    if (!enable) begin
      state_s  = IDLE;
      geldig_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = ZOEK;
        end
        ZOEK: begin
          if (beat_s) begin
            state_s   = METEN;
            beatcnt_s = '0;
          end else if (timeout_s) begin
            state_s = VERLOREN;
          end else begin
            state_s = ZOEK;
          end
        end
        METEN: begin
          if (accept_s) begin
            beatcnt_s = beatcnt_r + BEAT_W'(1);
            if (beatcnt_s == BEAT_LOCK) begin
              state_s    = VOLG;
              hartslag_s = meting;
              geldig_s   = 1'b1;
              verloren_s = 1'b0;
              retry_s    = '0;
            end else begin
              state_s = METEN;
            end
          end else if (timeout_s) begin
            state_s = VERLOREN;
          end else begin
            state_s = METEN;
          end
        end
        VOLG: begin
          if (accept_s) begin
            hartslag_s = meting;
          end else if (timeout_s) begin
            state_s = VERLOREN;
          end else begin
            state_s = VOLG;
          end
        end
        VERLOREN: begin
          state_s = ZOEK;
        end
        default: begin
          state_s = IDLE;
        end
      endcase

      // VERLOREN is only ever entered from another state, so this is the entry action.
      if (state_s == VERLOREN) begin
        geldig_s   = 1'b0;
        verloren_s = 1'b1;
        if (retry_inc_s == RETRY_MAX) begin
          retry_s    = '0;
          snelheid_s = sat_add8(snelheid_r, SNELHEID_STAP);
        end else begin
          retry_s = retry_inc_s;
        end
      end else begin
        snelheid_s = snelheid_r;
      end
    end
  end

  // Interval counter: restarts on every state entry and on each accepted beat.
  always_comb begin
    cnt_s = cnt_r;
    if ((state_s != state_r) || accept_s) begin
      cnt_s = '0;
    end else if (tick && (cnt_r != CNT_MAX)) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_s = cnt_r;
    end
  end

  assign meetreset_s = (state_s == IDLE) || (state_s == VERLOREN);

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      beatcnt_r   <= '0;
      retry_r     <= '0;
      snelheid_r  <= SNELHEID_INIT;
      hartslag_r  <= 8'd0;
      meetreset_r <= 1'b1;
      geldig_r    <= 1'b0;
      verloren_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      beatcnt_r   <= beatcnt_s;
      retry_r     <= retry_s;
      snelheid_r  <= snelheid_s;
      hartslag_r  <= hartslag_s;
      meetreset_r <= meetreset_s;
      geldig_r    <= geldig_s;
      verloren_r  <= verloren_s;
    end
  end

  assign ClockSnelheid = snelheid_r;
  assign meetReset     = meetreset_r;
  assign hartslag      = hartslag_r;
  assign geldig        = geldig_r;
  assign verloren      = verloren_r;
  assign toestand      = state_r;

endmodule

// File: tb/tb_hart_regelaar.sv
// Directed scoreboard bench for hart_regelaar: loss, lock, artefacts, boundary beat, divider stepping, enable/reset.
module tb_hart_regelaar;
  import hart_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       tick;
  logic       hartslagIngang;
  logic [7:0] meting;
  logic [7:0] ClockSnelheid;
  logic       meetReset;
  logic [7:0] hartslag;
  logic       geldig;
  logic       verloren;
  logic [2:0] toestand;

  int total = 0;
  int bad   = 0;
  int loss_seen = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];

  hart_regelaar dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .tick           (tick),
    .hartslagIngang (hartslagIngang),
    .meting         (meting),
    .ClockSnelheid  (ClockSnelheid),
    .meetReset      (meetReset),
    .hartslag       (hartslag),
    .geldig         (geldig),
    .verloren       (verloren),
    .toestand       (toestand)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (toestand == 3'(VERLOREN)) loss_seen <= loss_seen + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0d expected=<none>", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic send_beat();
    hartslagIngang = 1'b1;
    step(2);
    hartslagIngang = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (toestand !== s && n < budget) begin
      step(1);
      n++;
    end
  endtask

  task automatic check_reset_values(input string pfx);
    push({pfx, "_toestand"}, IDLE);        check(toestand);
    push({pfx, "_snelheid"}, 100);         check(ClockSnelheid);
    push({pfx, "_meetreset"}, 1);          check(meetReset);
    push({pfx, "_hartslag"}, 0);           check(hartslag);
    push({pfx, "_geldig"}, 0);             check(geldig);
    push({pfx, "_verloren"}, 0);           check(verloren);
  endtask

  // From ZOEK: one start beat, then four accepted beats 50 ticks apart.
  task automatic do_lock(input logic [7:0] m);
    meting = m;
    send_beat(); step(48);
    for (int i = 0; i < 3; i++) begin
      send_beat(); step(48);
    end
    push("prelock_toestand", METEN);  check(toestand);
    push("prelock_geldig", 0);        check(geldig);
    send_beat(); step(1);
    push("lock_lag_geldig", 0);       check(geldig);
    step(1);
    push("lock_geldig", 1);           check(geldig);
    push("lock_hartslag", m);         check(hartslag);
    push("lock_verloren", 0);         check(verloren);
    push("lock_toestand", VOLG);      check(toestand);
  endtask

  initial begin
    int n;
    int exp_spd;
    int exp_retry;

    reset = 1'b1; enable = 1'b0; tick = 1'b0; hartslagIngang = 1'b0; meting = 8'd0;
    step(3);
    check_reset_values("rst");

    // 1: no beats -> loss after 200 ticks
    reset = 1'b0; enable = 1'b1; tick = 1'b1;
    step(1);
    push("t1_zoek", ZOEK);            check(toestand);
    push("t1_meetreset_low", 0);      check(meetReset);
    push("t1_loss_interval", 201);
    wait_state(VERLOREN, 300, n);     check(n);
    push("t1_loss_meetreset", 1);     check(meetReset);
    push("t1_loss_verloren", 1);      check(verloren);
    push("t1_loss_geldig", 0);        check(geldig);
    step(1);
    push("t1_back_zoek", ZOEK);       check(toestand);
    push("t1_back_meetreset", 0);     check(meetReset);
    push("t1_back_verloren", 1);      check(verloren);

    // 2: lock at 50-tick intervals
    do_lock(8'd72);

    // 3: artefact 10 ticks after the accepted beat is ignored, counter keeps running
    meting = 8'd80;
    step(6);
    send_beat(); step(2);
    push("t3_artefact_hartslag", 72); check(hartslag);
    push("t3_artefact_toestand", VOLG); check(toestand);
    step(14);
    send_beat(); step(2);
    push("t3_next_hartslag", 80);     check(hartslag);

    // 5: beat lands exactly when the counter hits the timeout
    meting = 8'd90;
    loss_seen = 0;
    step(197);
    send_beat(); step(2);
    step(1);
    push("t5_edge_toestand", VOLG);   check(toestand);
    push("t5_edge_hartslag", 90);     check(hartslag);
    push("t5_edge_verloren", 0);      check(verloren);
    push("t5_no_loss", 0);            check(loss_seen);

    // 6a: enable low from VOLG
    enable = 1'b0;
    step(1);
    push("t6_idle", IDLE);            check(toestand);
    push("t6_geldig", 0);             check(geldig);
    push("t6_meetreset", 1);          check(meetReset);
    push("t6_snelheid_hold", 100);    check(ClockSnelheid);
    push("t6_verloren_hold", 0);      check(verloren);
    push("t6_hartslag_hold", 90);     check(hartslag);

    // 4: repeated losses step the divider, saturating at 255
    enable = 1'b1;
    step(1);
    exp_spd = 100;
    exp_retry = 0;
    for (int k = 0; k < 51; k++) begin
      exp_retry++;
      if (exp_retry == 3) begin
        exp_retry = 0;
        exp_spd = (exp_spd + 10 > 255) ? 255 : exp_spd + 10;
      end
      push("t4_loss_interval", 201);
      push("t4_snelheid", exp_spd);
      wait_state(VERLOREN, 300, n);
      check(n);
      check(ClockSnelheid);
      step(1);
    end

    // 6b: relock, then reset while in VOLG
    do_lock(8'd72);
    push("t6b_snelheid", 255);        check(ClockSnelheid);
    reset = 1'b1;
    step(1);
    check_reset_values("t6b_rst");
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
